// File: rtl/multi_resync_filter.sv
// Bank of independent single-bit synchronisers with optional stability filter and edge pulses.
// Latency STAGES (+FILTER_CYCLES) edges; no backpressure, every input change is tracked.
module multi_resync_filter #(
    parameter int                  CHANNELS      = 4,
    parameter int                  STAGES        = 2,
    parameter int                  FILTER_CYCLES = 0,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [CHANNELS-1:0] i_signal,
    output logic [CHANNELS-1:0] o_signal,
    output logic [CHANNELS-1:0] o_rise,
    output logic [CHANNELS-1:0] o_fall,
    output logic                o_change
);

    if (STAGES < 2) begin : g_bad_stages
        $error("multi_resync_filter: STAGES must be at least 2");
    end

    (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] sync_q [STAGES];
    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] prev_q;

    // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= i_signal;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[STAGES-1];

    if (FILTER_CYCLES == 0) begin : g_bypass
        assign o_signal = sync_s;
    end else begin : g_filter
        localparam int            CW      = $clog2(FILTER_CYCLES + 1);
        localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

        logic [CW-1:0]       cnt_q [CHANNELS];
        logic [CW-1:0]       cnt_d [CHANNELS];
        logic [CHANNELS-1:0] sig_q;
        logic [CHANNELS-1:0] sig_d;

        // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
        always_comb begin
            sig_d = sig_q;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_d[c] = '0;
                if (sync_s[c] != sig_q[c]) begin
                    if (cnt_q[c] == CNT_MAX) begin
                        sig_d[c] = sync_s[c];
                    end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sig_q <= RESET_VALUE;
                for (int c = 0; c < CHANNELS; c++) begin
                    cnt_q[c] <= '0;
                end
            end else begin
                sig_q <= sig_d;
                for (int c = 0; c < CHANNELS; c++) begin
                    cnt_q[c] <= cnt_d[c];
                end
            end
        end

        assign o_signal = sig_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_q <= RESET_VALUE;
        end else begin
            prev_q <= o_signal;
        end
    end

    assign o_rise   = o_signal & ~prev_q;
    assign o_fall   = ~o_signal & prev_q;
    assign o_change = |(o_rise | o_fall);

endmodule

// File: doc/multi_resync_filter.md
Name: multi_resync_filter

Overview:
Parametrised bank of CHANNELS independent single-bit synchronisers into the i_clk domain. Chain depth is configurable. An optional per-channel glitch filter (stability counter) sits behind each chain, and each channel generates one-cycle rise/fall pulses. It replaces ad-hoc per-signal double-flop instances for status lines, request/ack levels and external pins that need a debounced level plus edge events in one domain.

Parameters:
CHANNELS, 4, number of independent channels (>=1)
STAGES, 2, synchroniser flops per channel (>=2; elaboration error otherwise)
FILTER_CYCLES, 0, consecutive stable cycles required before o_signal follows; 0 = filter bypassed
RESET_VALUE, '0 (CHANNELS bits), per-channel reset value of sync chain and o_signal

Ports:
i_clk  input  1  destination clock; all logic in this domain
i_rst_n  input  1  asynchronous, active-low reset
i_signal  input  CHANNELS  asynchronous inputs; each bit independent, no inter-bit coherency
o_signal  output  CHANNELS  synchronised, optionally filtered level
o_rise  output  CHANNELS  one-cycle pulse when o_signal[i] goes 0->1
o_fall  output  CHANNELS  one-cycle pulse when o_signal[i] goes 1->0
o_change  output  1  OR of all o_rise and o_fall bits, same cycle

Behaviour:
- Reset (async assert, sync-released by the system): all sync flops and o_signal = RESET_VALUE; filter counters = 0; o_rise, o_fall and o_change = 0. Reset mid-operation drops any pending count and emits no pulse.
- Sync chain: s[i] = last flop of a STAGES-deep chain clocked by i_clk. i_signal is sampled into flop 1 only. No logic between chain flops. Chain flops carry the async-reg attribute for constraint discovery.
- FILTER_CYCLES == 0:
  - o_signal[i] = s[i] (wire, no extra register).
  - Latency: STAGES edges from the first capturing edge.
- FILTER_CYCLES = F >= 1:
  - Per-channel counter, width $clog2(F+1), saturating at F-1.
  - If s[i] == o_signal[i]: counter <= 0.
  - If s[i] != o_signal[i] and counter < F-1: counter increments.
  - If s[i] != o_signal[i] and counter == F-1: o_signal[i] <= s[i] and counter <= 0.
  - Result: o_signal follows s after F consecutive differing cycles. Latency is STAGES+F edges.
  - A pulse on s shorter than F cycles never reaches o_signal. The counter restarts from 0 on every return to equality.
- Edge pulses:
  - Registered on the previous o_signal value, p[i].
  - o_rise[i] = o_signal[i] & ~p[i]; o_fall[i] = ~o_signal[i] & p[i]. Each is high for exactly one cycle, in the first cycle o_signal holds its new value.
  - p resets to RESET_VALUE, so no pulse is emitted out of reset.
- Channels are fully independent. Simultaneous edges on several channels give simultaneous pulses, and o_change stays high for that single cycle.
- Minimum input level width for guaranteed capture: F+1 cycles of i_clk (1 cycle when F = 0 is not guaranteed; 2 cycles recommended).
- No combinational path from any input to any output except i_rst_n.

Test Plan:
1. Reset: CHANNELS=4, RESET_VALUE=4'b1010, hold i_rst_n=0 with i_signal toggling -> o_signal=4'b1010. After release with i_signal=4'b1010, no o_rise, o_fall or o_change for 20 cycles.
2. Latency, STAGES=2, F=0: i_signal[0] 0->1 just before edge k -> o_signal[0]=1 after edge k+1. o_rise[0]=1 for exactly the cycle after edge k+1, then 0. o_change matches.
3. Filter reject, STAGES=3, F=4: i_signal[1] high for 3 cycles, then low -> o_signal[1] stays 0, no pulses. High for 4 cycles -> o_signal[1] rises at edge k+2+4, with one o_rise[1] pulse.
4. Counter restart, F=4: pattern high 3 cycles, low 1 cycle, high 4 cycles -> exactly one rise, timed from the start of the second high run.
5. Multi-channel: all four inputs toggle 0->1 on the same cycle, F=0 -> o_rise=4'b1111 for one cycle, o_change=1 for one cycle. Inputs fall on different cycles -> four separate o_fall pulses, each with o_change.
6. Reset mid-count: F=8, input high for 5 cycles, then i_rst_n pulsed low -> o_signal returns to RESET_VALUE, counter clears, no pulse. After release, input held high -> rise only after a full 8 stable cycles.
